rvseed_opfetch_stage: RTL and testbench
=======================================

Name: rvseed_opfetch_stage

Overview:
- Operand-fetch / ID-EX pipeline stage that sits directly downstream of the integer register file.
- Drives the two register-file read addresses from the decoded instruction.
- Resolves operands with x0 handling and EX/MEM and WB bypassing, detects load-use hazards, and registers the result for the execute stage.
- Uses a valid/ready handshake on both sides, plus a flush input for branch redirects.

Parameters:
- CPU_WIDTH, 32, datapath / register width.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard held instruction (redirect)
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage accepts instruction this cycle
- in_pc  in  CPU_WIDTH  instruction PC
- in_rs1  in  REG_ADDR_WIDTH  source 1 index
- in_rs2  in  REG_ADDR_WIDTH  source 2 index
- in_rs1_used  in  1  instruction reads rs1
- in_rs2_used  in  1  instruction reads rs2
- in_rd  in  REG_ADDR_WIDTH  destination index
- in_rd_wen  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- reg1_raddr  out  REG_ADDR_WIDTH  register file read address 1 (= in_rs1, combinational)
- reg2_raddr  out  REG_ADDR_WIDTH  register file read address 2 (= in_rs2, combinational)
- reg1_rdata  in  CPU_WIDTH  register file read data 1 (combinational read)
- reg2_rdata  in  CPU_WIDTH  register file read data 2
- exm_wen, exm_rd, exm_data, exm_is_load  in  1/REG_ADDR_WIDTH/CPU_WIDTH/1  EX/MEM result bypass
- wb_wen, wb_rd, wb_data  in  1/REG_ADDR_WIDTH/CPU_WIDTH  writeback bus (same values drive the register file write port)
- out_valid  out  1  execute-stage payload valid
- out_ready  in  1  execute stage accepts payload
- out_pc, out_op1, out_op2, out_rd, out_rd_wen, out_is_load  out  widths as inputs  registered payload

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; all out_* payload =0.
  - in_ready follows its combinational equation (evaluates 1 while out_valid=0 and no hazard).
- Operand select, per source s in {1,2}, highest priority first:
  - (a) rs==0 -> 0.
  - (b) exm_wen & exm_rd==rs & !exm_is_load -> exm_data.
  - (c) wb_wen & wb_rd==rs -> wb_data. The register file write is visible only after the edge, so the same-cycle write must be bypassed.
  - (d) regN_rdata.
- Hazard, combinational; unused sources (rsN_used=0) never cause a hazard. hazard=1 if any used rs != 0 and either:
  - out_valid & out_is_load & out_rd_wen & out_rd==rs, or
  - exm_wen & exm_is_load & exm_rd==rs.
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Edge update, in priority order:
  - flush: out_valid<=0; any input offered that cycle is dropped.
  - else in_valid & in_ready: load payload with the selected operands; out_valid<=1.
  - else out_ready: out_valid<=0. This inserts a bubble on hazard.
  - else hold.
- Payload registers change only on capture. They hold their last value when invalid; no clearing on bubble.
- Latency: 1 cycle from accepted input to out_valid. Full throughput of 1 instruction/cycle when no hazard and out_ready=1.
- While stalled, the operands are re-evaluated every cycle, so a later WB write is picked up on release.
- Async reset mid-transfer drops the held instruction with no partial state.
- x0 as rd with in_rd_wen=1 never causes a hazard and never matches bypass case (b) or (c), because (a) wins first.

Test Plan:
- Reset -> out_valid=0, out_op1=out_op2=0. Inject in_rs1=3, rs2=4 with regfile x3=0x11, x4=0x22 -> next cycle out_valid=1, op1=0x11, op2=0x22.
- EX/MEM bypass: exm_wen=1, exm_rd=5, exm_data=0xAAAA, regfile x5=0x1, in_rs1=5 -> op1=0xAAAA.
- WB bypass: wb_wen=1, wb_rd=7, wb_data=0x1234 in the same cycle as in_rs2=7 -> op2=0x1234. If exm also targets rd=7 with 0x5555 (non-load) -> op2=0x5555.
- Load-use: accepted load with rd=9, then an instruction with rs1=9 -> in_ready=0 for 1 cycle and one bubble (out_valid=0). When WB delivers x9=0xBEEF, the dependent instruction issues with op1=0xBEEF. Same sequence with rs1_used=0 -> no stall.
- x0: in_rs1=0 with exm_rd=0, exm_data=0xFFFF, wb_rd=0 -> op1=0, no stall.
- Backpressure/flush: out_ready=0 for 3 cycles -> payload stable, in_ready=0. Flush with in_valid=1 -> out_valid=0 next cycle and the input is not captured.

Source files
------------

// File: rtl/rvseed_opfetch_stage.sv
// rvseed_opfetch_stage: operand fetch with x0/EX-MEM/WB bypass, load-use stall and a
// valid/ready registered payload towards execute.
module rvseed_opfetch_stage #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CPU_WIDTH-1:0]      in_pc,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic                      in_rs1_used,
  input  logic                      in_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_rd_wen,
  input  logic                      in_is_load,
  output logic [REG_ADDR_WIDTH-1:0] reg1_raddr,
  output logic [REG_ADDR_WIDTH-1:0] reg2_raddr,
  input  logic [CPU_WIDTH-1:0]      reg1_rdata,
  input  logic [CPU_WIDTH-1:0]      reg2_rdata,
  input  logic                      exm_wen,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd,
  input  logic [CPU_WIDTH-1:0]      exm_data,
  input  logic                      exm_is_load,
  input  logic                      wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [CPU_WIDTH-1:0]      wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CPU_WIDTH-1:0]      out_pc,
  output logic [CPU_WIDTH-1:0]      out_op1,
  output logic [CPU_WIDTH-1:0]      out_op2,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_rd_wen,
  output logic                      out_is_load
);
  logic [CPU_WIDTH-1:0] op1, op2;
  logic                 haz1, haz2;
  assign reg1_raddr = in_rs1;
  assign reg2_raddr = in_rs2;
  // EX/MEM load data is not available yet, so a load there must stall rather than bypass
  assign op1 = (in_rs1 == '0) ? '0 :
               (exm_wen && exm_rd == in_rs1 && !exm_is_load) ? exm_data :
               (wb_wen && wb_rd == in_rs1) ? wb_data : reg1_rdata;
  assign op2 = (in_rs2 == '0) ? '0 :
               (exm_wen && exm_rd == in_rs2 && !exm_is_load) ? exm_data :
               (wb_wen && wb_rd == in_rs2) ? wb_data : reg2_rdata;
  assign haz1 = in_rs1_used && in_rs1 != '0 &&
                ((out_valid && out_is_load && out_rd_wen && out_rd == in_rs1) ||
                 (exm_wen && exm_is_load && exm_rd == in_rs1));
  assign haz2 = in_rs2_used && in_rs2 != '0 &&
                ((out_valid && out_is_load && out_rd_wen && out_rd == in_rs2) ||
                 (exm_wen && exm_is_load && exm_rd == in_rs2));
  assign in_ready = !flush && !haz1 && !haz2 && (!out_valid || out_ready);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
      out_is_load <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_op1     <= op1;
      out_op2     <= op2;
      out_rd      <= in_rd;
      out_rd_wen  <= in_rd_wen;
      out_is_load <= in_is_load;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rvseed_opfetch_stage.sv
// tb_rvseed_opfetch_stage: directed vectors for operand select, hazards, backpressure, flush, reset.
module tb_rvseed_opfetch_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rs1_used, in_rs2_used, in_rd_wen, in_is_load;
  logic [4:0]  reg1_raddr, reg2_raddr;
  logic [31:0] reg1_rdata, reg2_rdata;
  logic        exm_wen, exm_is_load, wb_wen;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_data, wb_data;
  logic        out_valid, out_ready, out_rd_wen, out_is_load;
  logic [31:0] out_pc, out_op1, out_op2;
  logic [4:0]  out_rd;
  logic [31:0] rf [32];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  assign reg1_rdata = rf[reg1_raddr];
  assign reg2_rdata = rf[reg2_raddr];
  rvseed_opfetch_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_used(in_rs1_used),
    .in_rs2_used(in_rs2_used), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
    .reg1_raddr(reg1_raddr), .reg2_raddr(reg2_raddr), .reg1_rdata(reg1_rdata),
    .reg2_rdata(reg2_rdata), .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
    .exm_is_load(exm_is_load), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op1(out_op1),
    .out_op2(out_op2), .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_is_load(out_is_load)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic ld);
    in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rs1_used = u1;
    in_rs2_used = u2; in_rd = rd; in_rd_wen = wen; in_is_load = ld;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[3] = 32'h11; rf[4] = 32'h22; rf[5] = 32'h1; rf[7] = 32'h99; rf[9] = 32'h0;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    exm_wen = 1'b0; exm_rd = '0; exm_data = '0; exm_is_load = 1'b0;
    wb_wen = 1'b0; wb_rd = '0; wb_data = '0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_op1", out_op1, 0);
    chk("rst_op2", out_op2, 0);
    chk("rst_in_ready", in_ready, 1);
    step(); step();
    rst_n = 1'b1;
    // plain register-file operands
    drive(32'h100, 5'd3, 5'd4, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
    #1 chk("raddr1", reg1_raddr, 3);
    chk("raddr2", reg2_raddr, 4);
    chk("basic_ready", in_ready, 1);
    step();
    chk("basic_valid", out_valid, 1);
    chk("basic_op1", out_op1, 32'h11);
    chk("basic_op2", out_op2, 32'h22);
    chk("basic_pc", out_pc, 32'h100);
    chk("basic_rd", out_rd, 1);
    // EX/MEM bypass
    exm_wen = 1'b1; exm_rd = 5'd5; exm_data = 32'hAAAA;
    drive(32'h104, 5'd5, 5'd4, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
    step();
    chk("exm_op1", out_op1, 32'hAAAA);
    chk("exm_op2", out_op2, 32'h22);
    exm_wen = 1'b0;
    // WB bypass, then EX/MEM overriding WB
    wb_wen = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
    drive(32'h108, 5'd3, 5'd7, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
    step();
    chk("wb_op2", out_op2, 32'h1234);
    exm_wen = 1'b1; exm_rd = 5'd7; exm_data = 32'h5555;
    step();
    chk("exm_over_wb", out_op2, 32'h5555);
    exm_wen = 1'b0; wb_wen = 1'b0;
    // load-use: one stall cycle, one bubble, operand from WB on release
    drive(32'h200, 5'd3, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    step();
    chk("ld_valid", out_valid, 1);
    chk("ld_is_load", out_is_load, 1);
    drive(32'h204, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    #1 chk("lu_stall", in_ready, 0);
    step();
    chk("lu_bubble", out_valid, 0);
    chk("lu_hold_pc", out_pc, 32'h200);
    exm_wen = 1'b1; exm_rd = 5'd9; exm_is_load = 1'b1;
    #1 chk("exm_ld_stall", in_ready, 0);
    in_rs1_used = 1'b0;
    #1 chk("exm_ld_unused", in_ready, 1);
    in_rs1_used = 1'b1; exm_wen = 1'b0; exm_is_load = 1'b0;
    wb_wen = 1'b1; wb_rd = 5'd9; wb_data = 32'hBEEF;
    #1 chk("lu_release", in_ready, 1);
    step();
    chk("lu_valid", out_valid, 1);
    chk("lu_op1", out_op1, 32'hBEEF);
    chk("lu_pc", out_pc, 32'h204);
    wb_wen = 1'b0;
    // same sequence with rs1 unused: no stall
    drive(32'h210, 5'd3, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    step();
    drive(32'h214, 5'd9, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
    #1 chk("unused_ready", in_ready, 1);
    step();
    chk("unused_valid", out_valid, 1);
    chk("unused_pc", out_pc, 32'h214);
    // x0: load to x0 ahead, bypass buses targeting x0
    drive(32'h220, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    exm_wen = 1'b1; exm_rd = 5'd0; exm_data = 32'hFFFF;
    wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    drive(32'h224, 5'd0, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    #1 chk("x0_ready", in_ready, 1);
    step();
    chk("x0_op1", out_op1, 0);
    chk("x0_op2", out_op2, 32'h22);
    chk("x0_pc", out_pc, 32'h224);
    exm_wen = 1'b0; wb_wen = 1'b0;
    // backpressure
    drive(32'h300, 5'd3, 5'd4, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
    step();
    out_ready = 1'b0;
    drive(32'h304, 5'd4, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", in_ready, 0);
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_pc", out_pc, 32'h300);
      chk("bp_op1", out_op1, 32'h11);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", in_ready, 1);
    step();
    chk("bp_next_pc", out_pc, 32'h304);
    chk("bp_next_op1", out_op1, 32'h22);
    // flush drops the offered instruction
    flush = 1'b1;
    drive(32'h308, 5'd3, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    #1 chk("fl_ready", in_ready, 0);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_pc", out_pc, 32'h304);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("fl_idle", out_valid, 0);
    // async reset mid-transfer
    drive(32'h400, 5'd3, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1);
    step();
    chk("ar_valid", out_valid, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("ar_drop", out_valid, 0);
    chk("ar_pc", out_pc, 0);
    chk("ar_load", out_is_load, 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
